// File: rtl/top.sv
// Two-digit hex seven-segment driver: registers the encoded upper and lower
// nibbles of Value onto common-cathode segment buses ({dp,g,f,e,d,c,b,a}).
module top (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] Value,
    output logic [7:0] SevenSegDig1,
    output logic [7:0] SevenSegDig2
);

    // Full 16-entry case with no default path, so no pattern outside the table can appear.
    function automatic logic [7:0] encode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'h3F;
            4'h1: seg = 8'h06;
            4'h2: seg = 8'h5B;
            4'h3: seg = 8'h4F;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'h6D;
            4'h6: seg = 8'h7D;
            4'h7: seg = 8'h07;
            4'h8: seg = 8'h7F;
            4'h9: seg = 8'h6F;
            4'hA: seg = 8'h77;
            4'hB: seg = 8'h7C;
            4'hC: seg = 8'h39;
            4'hD: seg = 8'h5E;
            4'hE: seg = 8'h79;
            4'hF: seg = 8'h71;
        endcase
        return seg;
    endfunction

    logic [7:0] dig1_next;
    logic [7:0] dig2_next;

    always_comb begin
        dig1_next = encode(Value[7:4]);
        dig2_next = encode(Value[3:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            SevenSegDig1 <= 8'h00;
            SevenSegDig2 <= 8'h00;
        end else begin
            SevenSegDig1 <= dig1_next;
            SevenSegDig2 <= dig2_next;
        end
    end

endmodule

// File: tb/tb_top.sv
// Self-checking bench for the two-digit seven-segment driver: directed vectors,
// multi-cycle corner sequences, full sweep and random stimulus against a glyph model.
module tb_top;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] Value;
    logic [7:0] SevenSegDig1;
    logic [7:0] SevenSegDig2;

    int errors = 0;
    int checks = 0;

    top dut (
        .clk         (clk),
        .rst         (rst),
        .Value       (Value),
        .SevenSegDig1(SevenSegDig1),
        .SevenSegDig2(SevenSegDig2)
    );

    always #5 clk = ~clk;

    // Each glyph as the set of lit segment letters.
    string glyph [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                          "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [7:0] model_seg(input logic [3:0] nib);
        logic [7:0] seg = 8'h00;
        string s = glyph[nib];
        for (int i = 0; i < s.len(); i++) seg[s[i] - "a"] = 1'b1;
        return seg;
    endfunction

    typedef struct {
        logic [7:0] val;
        logic [7:0] exp1;
        logic [7:0] exp2;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{8'h2A, 8'h5B, 8'h77};
        vecs[1] = '{8'h05, 8'h3F, 8'h6D};
        vecs[2] = '{8'h8F, 8'h7F, 8'h71};
        vecs[3] = '{8'hD3, 8'h5E, 8'h4F};
        vecs[4] = '{8'hFF, 8'h71, 8'h71};
        vecs[5] = '{8'hB9, 8'h7C, 8'h6F};

        // Reset with Value=FF for two edges
        rst   = 1'b1;
        Value = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            edge_step();
            check("reset_dig1", SevenSegDig1, 8'h00);
            check("reset_dig2", SevenSegDig2, 8'h00);
        end
        rst = 1'b0;

        foreach (vecs[i]) begin
            Value = vecs[i].val;
            edge_step();
            check($sformatf("vec%0d_dig1", i), SevenSegDig1, vecs[i].exp1);
            check($sformatf("vec%0d_dig2", i), SevenSegDig2, vecs[i].exp2);
        end

        // Latency: a change between edges stays invisible until the next edge
        Value = 8'h00;
        edge_step();
        check("lat_pre_dig1", SevenSegDig1, 8'h3F);
        check("lat_pre_dig2", SevenSegDig2, 8'h3F);
        #2;
        Value = 8'h8F;
        #1;
        check("lat_hold_dig1", SevenSegDig1, 8'h3F);
        check("lat_hold_dig2", SevenSegDig2, 8'h3F);
        edge_step();
        check("lat_post_dig1", SevenSegDig1, 8'h7F);
        check("lat_post_dig2", SevenSegDig2, 8'h71);

        // Mid-operation reset and recovery
        Value = 8'hD3;
        edge_step();
        check("mid_pre_dig1", SevenSegDig1, 8'h5E);
        check("mid_pre_dig2", SevenSegDig2, 8'h4F);
        rst = 1'b1;
        edge_step();
        check("mid_rst_dig1", SevenSegDig1, 8'h00);
        check("mid_rst_dig2", SevenSegDig2, 8'h00);
        rst = 1'b0;
        edge_step();
        check("mid_rec_dig1", SevenSegDig1, 8'h5E);
        check("mid_rec_dig2", SevenSegDig2, 8'h4F);

        // Full sweep
        for (int v = 0; v < 256; v++) begin
            Value = 8'(v);
            edge_step();
            check($sformatf("sweep%02h_dig1", v), SevenSegDig1, model_seg(Value[7:4]));
            check($sformatf("sweep%02h_dig2", v), SevenSegDig2, model_seg(Value[3:0]));
        end

        // Random values with occasional reset
        for (int i = 0; i < 300; i++) begin
            logic [7:0] e1, e2;
            Value = 8'($urandom);
            rst   = ($urandom_range(0, 9) == 0);
            e1 = rst ? 8'h00 : model_seg(Value[7:4]);
            e2 = rst ? 8'h00 : model_seg(Value[3:0]);
            edge_step();
            check("rand_dig1", SevenSegDig1, e1);
            check("rand_dig2", SevenSegDig2, e2);
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
